// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state type and default operand width for serial_subtractor
package serial_sub_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/half_subtractor.sv
// half_subtractor: single-bit difference and borrow-out, the building block of the full-subtractor bit cell
module half_subtractor (
  input  logic i_a,
  input  logic i_b,
  output logic o_d,
  output logic o_bout
);
  assign o_d    = i_a ^ i_b;
  assign o_bout = ~i_a & i_b;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b with start/busy/done handshake; SERIAL_SUB_OVF_EN adds the o_ovf signed-overflow output
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             o_ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br, r_borrow;
  logic             w_d1, w_bo1, w_d, w_bo2, w_br_next, w_accept, w_last;
  // full subtractor: first stage combines the operand bits, second folds in the running borrow
  half_subtractor u_hs0 (.i_a(r_a[0]), .i_b(r_b[0]), .o_d(w_d1), .o_bout(w_bo1));
  half_subtractor u_hs1 (.i_a(w_d1),   .i_b(r_br),   .o_d(w_d),  .o_bout(w_bo2));
  assign w_br_next = w_bo1 | w_bo2;
  assign w_accept  = (r_state != SHIFT) && i_start;
  assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // next state: a new start is also honoured in the done cycle for back-to-back throughput
  always_comb begin
    w_next = (r_state == SHIFT) ? (w_last ? DONE : SHIFT) : (i_start ? SHIFT : IDLE);
  end
  // handshake outputs decoded from state
  always_comb begin
    o_busy = (r_state == SHIFT);
    o_done = (r_state == DONE);
  end
  // operand shift registers, partial result, running borrow and bit counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= {w_d, r_res[WIDTH-1:1]};
      r_br  <= w_br_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end
  // result registers load on the last bit so they are visible in the done cycle and hold afterwards
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_last) begin
      r_diff   <= {w_d, r_res[WIDTH-1:1]};
      r_borrow <= w_br_next;
    end
  end
  assign o_diff   = r_diff;
  assign o_borrow = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb, r_b_msb, r_ovf;
  // operand sign bits are shifted out of the operand registers, so keep a copy for the overflow test
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_msb <= i_a[WIDTH-1];
        r_b_msb <= i_b[WIDTH-1];
      end
      if (w_last) r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end
  assign o_ovf = r_ovf;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench with an arithmetic reference model for serial_subtractor
module tb_serial_subtractor;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [W-1:0] a, b;
  logic         o_busy, o_done, o_borrow;
  logic [W-1:0] o_diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         o_ovf;
`endif
  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
    .o_busy(o_busy), .o_done(o_done), .o_diff(o_diff), .o_borrow(o_borrow)
`ifdef SERIAL_SUB_OVF_EN
    , .o_ovf(o_ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  int           m_rem = 0;
  logic         m_done = 0, m_borrow = 0, m_ovf = 0, m_valid = 0;
  logic [W-1:0] m_diff = 0, m_a = 0, m_b = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem = 0; m_done = 0; m_diff = 0; m_borrow = 0; m_ovf = 0;
    end else if (m_rem == 0 && start) begin
      m_rem = W; m_a = a; m_b = b; m_done = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        {m_borrow, m_diff} = {1'b0, m_a} - {1'b0, m_b};
        m_ovf  = (m_a[W-1] != m_b[W-1]) && (m_diff[W-1] != m_a[W-1]);
        m_done = 1;
      end
    end else m_done = 0;
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_busy", {31'b0, o_busy}, {31'b0, m_rem > 0});
      chk("cyc_done", {31'b0, o_done}, {31'b0, m_done});
      chk("cyc_diff", {24'b0, o_diff}, {24'b0, m_diff});
      chk("cyc_borrow", {31'b0, o_borrow}, {31'b0, m_borrow});
`ifdef SERIAL_SUB_OVF_EN
      chk("cyc_ovf", {31'b0, o_ovf}, {31'b0, m_ovf});
`endif
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [W-1:0] ed,
                        input logic eb, input logic eo, input string nm);
    int n, nb;
    @(negedge clk); start = 1; a = ta; b = tb_v;
    @(negedge clk); start = 0; a = W'($urandom); b = W'($urandom);
    n = 1; nb = 0;
    while (!o_done && n < 20) begin
      if (o_busy) nb++;
      @(negedge clk); n++;
    end
    chk({nm, "_latency"}, n, 9);
    chk({nm, "_busycyc"}, nb, 8);
    chk({nm, "_diff"}, {24'b0, o_diff}, {24'b0, ed});
    chk({nm, "_borrow"}, {31'b0, o_borrow}, {31'b0, eb});
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, "_ovf"}, {31'b0, o_ovf}, {31'b0, eo});
`else
    if (eo) checks = checks;
`endif
  endtask

  initial begin
    int nd, last, cyc;
    rst_n = 0; start = 0; a = 0; b = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, o_busy}, 0);
    chk("rst_done", {31'b0, o_done}, 0);
    chk("rst_diff", {24'b0, o_diff}, 0);
    chk("rst_borrow", {31'b0, o_borrow}, 0);
    rst_n = 1;
    run_op(8'd10, 8'd3, 8'd7, 1'b0, 1'b0, "10m3");
    run_op(8'd3, 8'd10, 8'hF9, 1'b1, 1'b0, "3m10");
    run_op(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, "0m0");
    run_op(8'hFF, 8'd1, 8'hFE, 1'b0, 1'b0, "FFm1");
    @(negedge clk); start = 1; a = 8'd20; b = 8'd5;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk); start = 1; a = 8'd1; b = 8'd2;
    @(negedge clk); start = 0;
    nd = 0;
    repeat (15) begin
      if (o_done) begin
        nd++;
        chk("ign_diff", {24'b0, o_diff}, 15);
        chk("ign_borrow", {31'b0, o_borrow}, 0);
      end
      @(negedge clk);
    end
    chk("ign_donecount", nd, 1);
    @(negedge clk); start = 1; a = 8'd50; b = 8'd7;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_busy", {31'b0, o_busy}, 0);
    chk("midrst_done", {31'b0, o_done}, 0);
    chk("midrst_diff", {24'b0, o_diff}, 0);
    chk("midrst_borrow", {31'b0, o_borrow}, 0);
    rst_n = 1;
    nd = 0;
    repeat (10) begin
      if (o_done) nd++;
      @(negedge clk);
    end
    chk("midrst_nodone", nd, 0);
    run_op(8'd9, 8'd9, 8'd0, 1'b0, 1'b0, "9m9");
    @(negedge clk); start = 1; a = 8'd100; b = 8'd1;
    nd = 0; last = -1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (o_done) begin
        nd++;
        chk("b2b_diff", {24'b0, o_diff}, 99);
        if (last >= 0) chk("b2b_period", cyc - last, 9);
        else chk("b2b_first", cyc, 9);
        last = cyc;
      end
    end
    chk("b2b_donecount", nd, 4);
    start = 0;
    repeat (12) @(negedge clk);
`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "ovf80m01");
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "ovf7FmFF");
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "ovf05m03");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
